counter_seq_ctrl: RTL
=====================

// Module: counter_seq_ctrl
// PURPOSE
//  Single-clock sequencer for the two-counter/adder datapath. Replaces the
//  dual-clock reset generator: issues interleaved count enables (en1/en2),
//  a synchronous load pulse with init values, and reloads both counters
//  whenever the adder sum exceeds a run-time threshold. Sits beside the two
//  Counter instances and the Adder; consumes the adder output as 'sum'.
// PARAMETERS
//  SIZE   8   width of counter values, sum, threshold and init values
//  INIT1  0   value driven on init1 (counter 1 load value)
//  INIT2  1   value driven on init2 (counter 2 load value)
//  CNT_W  8   width of wrap_cnt (only with CTRL_WRAPCNT_EN)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  start      in   1      level; IDLE->LOAD when high
//  stop       in   1      level; any state->IDLE when high (not in reset)
//  threshold  in   SIZE   unsigned reload threshold, sampled every cycle
//  sum        in   SIZE   adder output (val1+val2, mod 2^SIZE)
//  en1        out  1      count enable, counter 1
//  en2        out  1      count enable, counter 2
//  load       out  1      synchronous load: counters take init1/init2
//  init1      out  SIZE   constant INIT1
//  init2      out  SIZE   constant INIT2
//  busy       out  1      high in every state except IDLE
//  wrap       out  1      high in RELOAD state (one cycle per reload)
//  wrap_cnt   out  CNT_W  reloads since LOAD (only with CTRL_WRAPCNT_EN)
// BEHAVIOUR
//  - States: IDLE, LOAD, RUN_A, RUN_B, RELOAD. Outputs are pure decodes of
//    the state register (Moore): LOAD/RELOAD->load=1; RUN_A->en1=1;
//    RUN_B->en2=1; at most one of en1/en2/load high in any cycle.
//  - rst_n low: state=IDLE immediately; en1=en2=load=busy=wrap=0,
//    wrap_cnt=0. Deassertion takes effect at next rising edge.
//  - Transitions, priority stop > threshold > sequencing:
//    IDLE:   start & !stop -> LOAD; else stay.
//    LOAD:   stop -> IDLE; else RUN_A.
//    RUN_A:  stop -> IDLE; sum>threshold -> RELOAD; else RUN_B.
//    RUN_B:  stop -> IDLE; sum>threshold -> RELOAD; else RUN_A.
//    RELOAD: stop -> IDLE; else RUN_A (threshold not checked in RELOAD).
//  - Compare is unsigned SIZE-bit, strict '>'. threshold = 2^SIZE-1 never
//    reloads; counters then wrap naturally mod 2^SIZE and sum wraps too.
//  - sum reflects enables of the previous cycle, so the counter enabled in
//    the cycle that detects the overflow still increments once (one-count
//    overshoot, by design; RELOAD clears it).
//  - start and stop both high in IDLE: stay IDLE. start ignored outside IDLE.
//  - stop mid-run: next cycle IDLE, counters hold (no load issued); a later
//    start always passes through LOAD first.
//  - threshold change takes effect on the next compare; no latching.
// CONFIGURATION
//  CTRL_WRAPCNT_EN defined: wrap_cnt port present; cleared in LOAD,
//   +1 on each entry to RELOAD, saturates at 2^CNT_W-1; holds in IDLE.
//  CTRL_WRAPCNT_EN undefined: no wrap_cnt port, no counter logic; all
//   other behaviour identical.
// TESTING (bench models Counter+Adder, SIZE=8, INIT1=0, INIT2=1)
//  1 Reset: rst_n=0 mid-RUN_B -> all outputs 0 same cycle, IDLE after release.
//  2 start=1 one cycle, threshold=10 -> load cyc0, en1/en2 alternate from
//    cyc1, sum=11 seen cyc11, load (wrap=1) cyc12, en1 cyc13; period 12.
//  3 stop=1 in RUN_A with sum=5 -> IDLE next cycle, sum stays 6, busy=0;
//    start again -> load then sum=1.
//  4 threshold=255 -> no wrap; sum goes 254,255,0,1 across wrap.
//  5 start=stop=1 in IDLE -> stays IDLE, load never asserted.
//  6 CTRL_WRAPCNT_EN, CNT_W=2, threshold=3 -> wrap_cnt 1,2,3,3 over four
//    reloads; restart via stop/start -> 0.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// Single-clock sequencer for the two-counter/adder datapath: interleaved count enables,
// load/reload pulses on sum > threshold. Optional reload counter via CTRL_WRAPCNT_EN.
module counter_seq_ctrl #(
    parameter int              SIZE  = 8,
    parameter logic [SIZE-1:0] INIT1 = '0,
    parameter logic [SIZE-1:0] INIT2 = SIZE'(1)
`ifdef CTRL_WRAPCNT_EN
    ,
    parameter int              CNT_W = 8
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic [SIZE-1:0] threshold,
    input  logic [SIZE-1:0] sum,
    output logic            en1,
    output logic            en2,
    output logic            load,
    output logic [SIZE-1:0] init1,
    output logic [SIZE-1:0] init2,
    output logic            busy,
    output logic            wrap
`ifdef CTRL_WRAPCNT_EN
    ,
    output logic [CNT_W-1:0] wrap_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN_A,
        S_RUN_B,
        S_RELOAD
    } state_e;

    state_e state_q, state_d;
    logic   en1_q, en2_q, load_q, busy_q, wrap_q;

    assign init1 = INIT1;
    assign init2 = INIT2;
    assign en1   = en1_q;
    assign en2   = en2_q;
    assign load  = load_q;
    assign busy  = busy_q;
    assign wrap  = wrap_q;

    always_comb begin
        // NOTE: the default assignment first keeps this block free of inferred latches.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start && !stop) state_d = S_LOAD;
            S_LOAD:   state_d = stop ? S_IDLE : S_RUN_A;
            S_RUN_A: begin
                if (stop)                  state_d = S_IDLE;
                else if (sum > threshold)  state_d = S_RELOAD;
                else                       state_d = S_RUN_B;
            end
            S_RUN_B: begin
                if (stop)                  state_d = S_IDLE;
                else if (sum > threshold)  state_d = S_RELOAD;
                else                       state_d = S_RUN_A;
            end
            S_RELOAD: state_d = stop ? S_IDLE : S_RUN_A;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state, so they track state_q exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            en1_q   <= (state_d == S_RUN_A);
            en2_q   <= (state_d == S_RUN_B);
            load_q  <= (state_d == S_LOAD) || (state_d == S_RELOAD);
            busy_q  <= (state_d != S_IDLE);
            wrap_q  <= (state_d == S_RELOAD);
        end
    end

`ifdef CTRL_WRAPCNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] wrap_cnt_q;

    assign wrap_cnt = wrap_cnt_q;

    // RELOAD always exits after one cycle, so every RELOAD cycle is a fresh entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_cnt_q <= '0;
        end else if (state_d == S_LOAD) begin
            wrap_cnt_q <= '0;
        end else if ((state_d == S_RELOAD) && (wrap_cnt_q != CNT_MAX)) begin
            wrap_cnt_q <= wrap_cnt_q + CNT_W'(1);
        end
    end
`endif

endmodule
